// File: rtl/ising_axil_pkg.sv
// Shared response codes, FSM state types and cell range helper for the
// ising weight-array AXI4-Lite bridge.
package ising_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_STROBE = 2'd1,
        W_RESP   = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    function automatic logic cell_in_range(input logic [63:0] idx, input int unsigned ncells);
        return idx < 64'(ncells);
    endfunction

endpackage

// File: rtl/cell_addr_decode.sv
// Word index to one-hot cell match plus in-range flag for an N x N array.
module cell_addr_decode
    import ising_axil_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 30
) (
    input  logic [IDX_W-1:0] idx,
    output logic [N*N-1:0]   match,
    output logic             in_range
);

    localparam int NCELLS = N * N;
    localparam int SEL_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    always_comb begin
        match    = '0;
        in_range = cell_in_range(64'(idx), NCELLS);
        if (in_range) begin
            match[idx[SEL_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/ising_weight_axil.sv
// AXI4-Lite responder for the coupled-cell weight array: writes become one-cycle
// one-hot strobes, reads select a cell. Optional macro: WEIGHT_ONEHOT_CHECK_EN.
module ising_weight_axil
    import ising_axil_pkg::*;
#(
    parameter int N           = 8,
    parameter int NUM_WEIGHTS = 15,
    parameter int ADDR_W      = 32
) (
    input  logic                                     clk,
    input  logic                                     axi_rst,
    input  logic [ADDR_W-1:0]                        s_axi_awaddr,
    input  logic                                     s_axi_awvalid,
    output logic                                     s_axi_awready,
    input  logic [31:0]                              s_axi_wdata,
    input  logic [3:0]                               s_axi_wstrb,
    input  logic                                     s_axi_wvalid,
    output logic                                     s_axi_wready,
    output logic [1:0]                               s_axi_bresp,
    output logic                                     s_axi_bvalid,
    input  logic                                     s_axi_bready,
    input  logic [ADDR_W-1:0]                        s_axi_araddr,
    input  logic                                     s_axi_arvalid,
    output logic                                     s_axi_arready,
    output logic [31:0]                              s_axi_rdata,
    output logic [1:0]                               s_axi_rresp,
    output logic                                     s_axi_rvalid,
    input  logic                                     s_axi_rready,
    output logic                                     cell_wready,
    output logic [N*N-1:0]                           cell_wr_addr_match,
    output logic [31:0]                              cell_wdata,
    output logic [((N*N > 1) ? $clog2(N*N) : 1)-1:0] cell_rd_sel,
    input  logic [31:0]                              cell_rdata
);

    localparam int NCELLS = N * N;
    localparam int SEL_W  = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int IDX_W  = ADDR_W - 2;

    w_state_t          w_state;
    r_state_t          r_state;
    logic              aw_held, w_held;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_nx, ar_idx;
    logic [31:0]       wdata_q, wdata_nx;
    logic [3:0]        wstrb_q, wstrb_nx;
    logic              aw_hs, w_hs, ar_hs, wr_go, wr_err, data_bad;
    logic              dec_in_range, rd_ok_q;
    logic [NCELLS-1:0] dec_match;
    logic              unused_bits;

`ifdef WEIGHT_ONEHOT_CHECK_EN
    function automatic logic weight_bad(input logic [31:0] d);
        return ($countones(d[NUM_WEIGHTS-1:0]) != 1) || (d[31:NUM_WEIGHTS] != '0);
    endfunction
`endif

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign ar_idx    = s_axi_araddr[ADDR_W-1:2];

    // Channels captured this very cycle are used directly so the strobe lands one cycle later.
    assign aw_idx_nx = aw_hs ? s_axi_awaddr[ADDR_W-1:2] : aw_idx_q;
    assign wdata_nx  = w_hs ? s_axi_wdata : wdata_q;
    assign wstrb_nx  = w_hs ? s_axi_wstrb : wstrb_q;
    assign wr_go     = (aw_held | aw_hs) & (w_held | w_hs);

    always_comb begin
`ifdef WEIGHT_ONEHOT_CHECK_EN
        data_bad = weight_bad(wdata_nx);
`else
        data_bad = 1'b0;
`endif
    end

    assign wr_err      = !dec_in_range || (wstrb_nx != 4'hF) || data_bad;
    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wdata_nx[31:NUM_WEIGHTS]};

    cell_addr_decode #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_wr_decode (
        .idx      (aw_idx_nx),
        .match    (dec_match),
        .in_range (dec_in_range)
    );

    always_ff @(posedge clk) begin
        if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
        if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
        end
    end

    // Write path: capture AW/W -> one strobe cycle -> response
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            w_state            <= W_IDLE;
            aw_held            <= 1'b0;
            w_held             <= 1'b0;
            s_axi_awready      <= 1'b1;
            s_axi_wready       <= 1'b1;
            s_axi_bvalid       <= 1'b0;
            s_axi_bresp        <= RESP_OKAY;
            cell_wready        <= 1'b0;
            cell_wr_addr_match <= '0;
            cell_wdata         <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held       <= 1'b1;
                        s_axi_awready <= 1'b0;
                    end
                    if (w_hs) begin
                        w_held       <= 1'b1;
                        s_axi_wready <= 1'b0;
                    end
                    if (wr_go) begin
                        w_state            <= W_STROBE;
                        cell_wready        <= !wr_err;
                        cell_wr_addr_match <= wr_err ? '0 : dec_match;
                        cell_wdata         <= 32'(wdata_nx[NUM_WEIGHTS-1:0]);
                        s_axi_bresp        <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_STROBE: begin
                    cell_wready        <= 1'b0;
                    cell_wr_addr_match <= '0;
                    s_axi_bvalid       <= 1'b1;
                    w_state            <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read path: capture AR -> select cell -> register data
    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            cell_rd_sel   <= '0;
            rd_ok_q       <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_arready <= 1'b0;
                        cell_rd_sel   <= ar_idx[SEL_W-1:0];
                        rd_ok_q       <= cell_in_range(64'(ar_idx), NCELLS);
                        r_state       <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s_axi_rdata  <= rd_ok_q ? cell_rdata : 32'd0;
                    s_axi_rresp  <= rd_ok_q ? RESP_OKAY : RESP_SLVERR;
                    s_axi_rvalid <= 1'b1;
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_weight_axil.sv
// Directed bench for ising_weight_axil with a scoreboard of expected responses.
module tb_ising_weight_axil;

    logic        clk = 1'b0;
    logic        axi_rst;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        cell_wready;
    logic [63:0] cell_wr_addr_match;
    logic [31:0] cell_wdata;
    logic [5:0]  cell_rd_sel;
    logic [31:0] cell_rdata;

    logic        mem_load;
    logic [31:0] mem [64];

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    always #5 clk = ~clk;

    ising_weight_axil #(.N(8), .NUM_WEIGHTS(15), .ADDR_W(32)) dut (
        .clk                (clk),
        .axi_rst            (axi_rst),
        .s_axi_awaddr       (s_axi_awaddr),
        .s_axi_awvalid      (s_axi_awvalid),
        .s_axi_awready      (s_axi_awready),
        .s_axi_wdata        (s_axi_wdata),
        .s_axi_wstrb        (s_axi_wstrb),
        .s_axi_wvalid       (s_axi_wvalid),
        .s_axi_wready       (s_axi_wready),
        .s_axi_bresp        (s_axi_bresp),
        .s_axi_bvalid       (s_axi_bvalid),
        .s_axi_bready       (s_axi_bready),
        .s_axi_araddr       (s_axi_araddr),
        .s_axi_arvalid      (s_axi_arvalid),
        .s_axi_arready      (s_axi_arready),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .cell_wready        (cell_wready),
        .cell_wr_addr_match (cell_wr_addr_match),
        .cell_wdata         (cell_wdata),
        .cell_rd_sel        (cell_rd_sel),
        .cell_rdata         (cell_rdata)
    );

    function automatic logic [31:0] init_w(input int i);
        return (i == 2) ? 32'h0000_0080 : 32'h0000_1000 + 32'(i);
    endfunction

    // Behavioural weight array: combinational read, strobed write
    assign cell_rdata = mem[cell_rd_sel];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_w(i);
        end else if (cell_wready) begin
            for (int i = 0; i < 64; i++) if (cell_wr_addr_match[i]) mem[i] <= cell_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_b();
        check("bvalid", s_axi_bvalid, 1);
        check("bresp", s_axi_bresp, bq.pop_front());
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bvalid_clear", s_axi_bvalid, 0);
        check("awready_back", s_axi_awready, 1);
    endtask

    task automatic finish_r(input int hold);
        logic [31:0] first;
        check("rvalid", s_axi_rvalid, 1);
        check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, rq.pop_front());
        first = s_axi_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rvalid_hold", s_axi_rvalid, 1);
            check("rdata_hold", s_axi_rdata, first);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("rvalid_clear", s_axi_rvalid, 0);
        check("arready_back", s_axi_arready, 1);
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input bit exp_strobe, input logic [31:0] exp_wdata,
                            input logic [1:0] exp_resp);
        logic [63:0] exp_match;
        exp_match    = exp_strobe ? (64'd1 << addr[7:2]) : 64'd0;
        bq.push_back(exp_resp);
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        if (order == 0) begin
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            tick();
        end else if (order == 1) begin
            s_axi_wvalid = 1'b1;
            tick();
            s_axi_wvalid  = 1'b0;
            s_axi_awvalid = 1'b1;
            tick();
        end else begin
            s_axi_awvalid = 1'b1;
            tick();
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b1;
            tick();
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("cell_wready", cell_wready, exp_strobe);
        check("cell_match", cell_wr_addr_match, exp_match);
        if (exp_strobe) check("cell_wdata", cell_wdata, exp_wdata);
        tick();
        check("wready_after_strobe", cell_wready, 0);
        finish_b();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
        rq.push_back({exp_resp, exp_data});
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("arready_busy", s_axi_arready, 0);
        if (exp_resp == OKAY) check("cell_rd_sel", cell_rd_sel, addr[7:2]);
        tick();
        finish_r(hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_rst = 1'b1;
        mem_load = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (2) tick();
        axi_rst = 1'b0;
        mem_load = 1'b0;
        tick();

        check("rst_awready", s_axi_awready, 1);
        check("rst_wready", s_axi_wready, 1);
        check("rst_arready", s_axi_arready, 1);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_cell_wready", cell_wready, 0);
        check("rst_match", cell_wr_addr_match, 0);
        check("rst_cell_wdata", cell_wdata, 0);
        check("rst_rd_sel", cell_rd_sel, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_bresp", s_axi_bresp, 0);
        check("rst_rresp", s_axi_rresp, 0);

        do_write(32'h0C, 32'h0001, 4'hF, 0, 1'b1, 32'h0001, OKAY);
        do_write(32'h100, 32'h0001, 4'hF, 1, 1'b0, 32'h0, SLVERR);
        do_write(32'h10, 32'h0002, 4'h3, 2, 1'b0, 32'h0, SLVERR);
`ifdef WEIGHT_ONEHOT_CHECK_EN
        do_write(32'h00, 32'h0003, 4'hF, 0, 1'b0, 32'h0, SLVERR);
        do_write(32'h00, 32'h4000, 4'hF, 0, 1'b1, 32'h4000, OKAY);
        do_write(32'h18, 32'hFFFF_0001, 4'hF, 2, 1'b0, 32'h0, SLVERR);
        do_read(32'h18, 32'h0000_1006, OKAY, 0);
`else
        do_write(32'h00, 32'h0003, 4'hF, 0, 1'b1, 32'h0003, OKAY);
        do_write(32'h18, 32'hFFFF_0001, 4'hF, 2, 1'b1, 32'h0001, OKAY);
        do_read(32'h18, 32'h0000_0001, OKAY, 0);
`endif

        do_read(32'h08, 32'h0000_0080, OKAY, 5);
        do_read(32'h0C, 32'h0000_0001, OKAY, 0);
        do_read(32'h10, 32'h0000_1004, OKAY, 0);
        do_read(32'h100, 32'h0, SLVERR, 0);

        // Write and read of cell 5 with FETCH aligned to STROBE
        bq.push_back(OKAY);
        rq.push_back({OKAY, 32'h0000_1005});
        s_axi_awaddr = 32'h14; s_axi_wdata = 32'h0100; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h14;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("coinc_strobe", cell_wready, 1);
        check("coinc_rd_sel", cell_rd_sel, 5);
        tick();
        finish_r(0);
        finish_b();
        do_read(32'h14, 32'h0000_0100, OKAY, 0);

        // Reset during the strobe cycle
        s_axi_awaddr = 32'h1C; s_axi_wdata = 32'h0200; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("rst_mid_strobe_before", cell_wready, 1);
        axi_rst = 1'b1;
        #1;
        check("rst_mid_async_wready", cell_wready, 0);
        check("rst_mid_async_match", cell_wr_addr_match, 0);
        tick();
        axi_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_no_bvalid", s_axi_bvalid, 0);
        end
        check("rst_mid_awready", s_axi_awready, 1);
        do_read(32'h1C, 32'h0000_1007, OKAY, 0);

        check("bq_drained", bq.size(), 0);
        check("rq_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
